// File: rtl/hazard_ctrl_pipe.sv
// Control-side pipeline stage behind the opcode decoder: carries the control bundle
// through ID/EX, EX/MEM and MEM/WB, resolves load-use stalls and branch/jump flushes.
module hazard_ctrl_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       ID_Ctrl,
    input  logic             ID_Jump,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic [4:0]       ID_Rd,
    input  logic             EX_Zero,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             PCSrc,
    output logic             JumpSel,
    output logic [8:0]       EX_Ctrl,
    output logic [4:0]       EX_Rs,
    output logic [4:0]       EX_Rt,
    output logic [4:0]       EX_WriteReg,
    output logic [3:0]       MEM_Ctrl,
    output logic [4:0]       MEM_WriteReg,
    output logic [1:0]       WB_Ctrl,
    output logic [4:0]       WB_WriteReg,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    // Bit positions inside the decoder bundle.
    localparam int REG_DST    = 8;
    localparam int BRANCH     = 7;
    localparam int MEM_READ   = 6;
    localparam int MEM_TO_REG = 5;
    localparam int MEM_WRITE  = 2;
    localparam int REG_WRITE  = 0;

    logic taken;
    logic stall;
    logic bubble;

    assign taken  = EX_Ctrl[BRANCH] & EX_Zero;
    // A jump in ID never reads its Rs/Rt fields, so it must not trip the load-use check.
    assign stall  = EX_Ctrl[MEM_READ] & (EX_Rt != 5'd0) &
                    ((EX_Rt == ID_Rs) | (EX_Rt == ID_Rt)) & ~ID_Jump;
    assign bubble = taken | stall;

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        PCSrc     = 1'b0;
        JumpSel   = 1'b0;
        if (taken) begin
            PCSrc     = 1'b1;
            IFIDFlush = 1'b1;
        end else if (stall) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
        end else if (ID_Jump) begin
            JumpSel   = 1'b1;
            IFIDFlush = 1'b1;
        end
    end

    // ID/EX: the only stage that can take a bubble.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers use non-blocking assignment so every stage samples pre-edge values.
        if (rst) begin
            EX_Ctrl     <= '0;
            EX_Rs       <= '0;
            EX_Rt       <= '0;
            EX_WriteReg <= '0;
        end else if (bubble) begin
            EX_Ctrl     <= '0;
            EX_Rs       <= '0;
            EX_Rt       <= '0;
            EX_WriteReg <= '0;
        end else begin
            EX_Ctrl     <= ID_Ctrl;
            EX_Rs       <= ID_Rs;
            EX_Rt       <= ID_Rt;
            EX_WriteReg <= ID_Ctrl[REG_DST] ? ID_Rd : ID_Rt;
        end
    end

    // EX/MEM and MEM/WB advance every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MEM_Ctrl     <= '0;
            MEM_WriteReg <= '0;
            WB_Ctrl      <= '0;
            WB_WriteReg  <= '0;
        end else begin
            MEM_Ctrl     <= {EX_Ctrl[MEM_READ], EX_Ctrl[MEM_WRITE],
                             EX_Ctrl[MEM_TO_REG], EX_Ctrl[REG_WRITE]};
            MEM_WriteReg <= EX_WriteReg;
            WB_Ctrl      <= MEM_Ctrl[1:0];
            WB_WriteReg  <= MEM_WriteReg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (stall && !taken && (StallCount != '1)) StallCount <= StallCount + CNT_W'(1);
            if (IFIDFlush && (FlushCount != '1))       FlushCount <= FlushCount + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_ctrl_pipe.md
Name: hazard_ctrl_pipe

Overview:
Control-side pipeline stage directly downstream of the main opcode decoder in the 5-stage MIPS core. It registers the decoder's control bundle through the ID/EX, EX/MEM and MEM/WB boundaries and carries the destination register number alongside. It also detects load-use hazards and inserts bubbles, resolves beq/j redirects and flushes, and keeps saturating stall and flush event counters.

Parameters:
CNT_W, 16, width of the StallCount and FlushCount performance counters

Ports:
clk  input  1  pipeline clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
ID_Ctrl  input  9  decoder bundle {RegDst, Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite}; bit 8 = RegDst
ID_Jump  input  1  decoder Jump for the instruction in ID
ID_Rs  input  5  IF/ID instr[25:21]
ID_Rt  input  5  IF/ID instr[20:16]
ID_Rd  input  5  IF/ID instr[15:11]
EX_Zero  input  1  ALU zero flag for the instruction currently in EX
PCWrite  output  1  PC load enable
IFIDWrite  output  1  IF/ID register load enable
IFIDFlush  output  1  IF/ID clear (turns the fetched instruction into a nop)
PCSrc  output  1  select branch target (EX_Branch & EX_Zero)
JumpSel  output  1  select jump target
EX_Ctrl  output  9  registered ID_Ctrl, same bit order
EX_Rs, EX_Rt  output  5 each  registered ID_Rs/ID_Rt (for forwarding unit)
EX_WriteReg  output  5  registered (RegDst ? ID_Rd : ID_Rt)
MEM_Ctrl  output  4  {MemRead, MemWrite, MemtoReg, RegWrite}
MEM_WriteReg  output  5  destination in MEM
WB_Ctrl  output  2  {MemtoReg, RegWrite}
WB_WriteReg  output  5  destination in WB
StallCount  output  CNT_W  number of load-use bubbles inserted, saturating
FlushCount  output  CNT_W  number of IF/ID flushes, saturating

Behaviour:
- Reset (async, immediate): all stage registers and both counters are 0. With zeroed stages, the combinational outputs read PCWrite=1, IFIDWrite=1, IFIDFlush=0, PCSrc=0, JumpSel=0.
- Internal signals:
  - Taken = EX_Ctrl[Branch] & EX_Zero.
  - Stall = EX_Ctrl[MemRead] & (EX_Rt != 0) & (EX_Rt == ID_Rs | EX_Rt == ID_Rt) & !ID_Jump. Jump field bits never cause a stall.
- Priority is Taken > Stall > Jump.
  - Taken: PCSrc=1, PCWrite=1, IFIDWrite=1, IFIDFlush=1, JumpSel=0. The ID/EX load is a bubble (Ctrl=0, WriteReg=0), because the ID instruction is wrong-path.
  - Stall (no Taken): PCWrite=0, IFIDWrite=0, IFIDFlush=0, JumpSel=0. The ID/EX load is a bubble.
  - ID_Jump (no Taken): JumpSel=1, IFIDFlush=1, PCWrite=1. ID/EX loads the decoder bundle verbatim.
  - Otherwise: PCWrite=1, IFIDWrite=1, and ID/EX loads ID_Ctrl, ID_Rs, ID_Rt and the WriteReg mux.
- EX/MEM and MEM/WB advance every cycle unconditionally; they are never stalled or flushed.
  - MEM_Ctrl takes fields from EX_Ctrl.
  - WB_Ctrl takes fields from MEM_Ctrl.
  - Latency ID to EX/MEM/WB is 1/2/3 cycles.
- The decoder bundle is carried bit-exact. The block does not reinterpret MemtoReg polarity (1 = ALU result) and does not mask any decoder output.
- Counters:
  - StallCount increments on each cycle with Stall & !Taken.
  - FlushCount increments on each cycle with IFIDFlush.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Reset asserted mid-stall or mid-flush clears all state immediately. The first post-reset cycle behaves as the normal case.

Test Plan:
1. Load-use: lw $t0 in ID (MemRead=1, Rt=8); next cycle ID_Rs=8 -> Stall. PCWrite=0, IFIDWrite=0. EX_Ctrl=0 after the edge. StallCount 0->1. The following cycle proceeds normally, with MEM_Ctrl=4'b1001 for the lw.
2. lw with Rt=0 followed by a user of $0 -> no stall. PCWrite stays 1 and StallCount stays 0.
3. beq with Branch=1 in EX and EX_Zero=1 while a load-use condition is also present -> Taken wins. PCSrc=1, IFIDFlush=1, PCWrite=1, EX_Ctrl=0 after the edge. FlushCount +1, StallCount unchanged.
4. j in ID (ID_Jump=1, ID_Rs field equals a pending lw Rt) -> no stall. JumpSel=1, IFIDFlush=1.
5. R-format addu, RegDst=1, Rd=10, Rt=9 -> EX_WriteReg=10, MEM_WriteReg=10 one cycle later, WB_WriteReg=10 and WB_Ctrl=2'b11 one cycle after that.
6. Force 2^CNT_W+3 stalls with CNT_W=4 -> StallCount holds 15. Asserting rst mid-stall clears all registered outputs to 0 asynchronously.
